// File: rtl/pixel_buffer_mux_if.sv
// Pixel stream bundle between the ray-pipe channels, the merging FIFO and the frame buffer handler.
// The slave modport is the FIFO/arbiter side; the master modport is the producer/consumer side.
interface pixel_buffer_mux_if #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 64,
  parameter int FRAME_PIXELS = 307200
);
  logic [NUM_CH-1:0]                  in_valid;
  logic [NUM_CH-1:0][DATA_W-1:0]      in_data;
  logic [NUM_CH-1:0]                  in_ready;
  logic                               re;
  logic [DATA_W-1:0]                  data_out;
  logic                               empty;
  logic                               full;
  logic [$clog2(DEPTH):0]             num_in_fifo;
  logic [$clog2(FRAME_PIXELS)-1:0]    pix_idx;
  logic                               frame_done;
  logic [15:0]                        frame_cnt;
  logic                               err;

  modport slave (
    input  in_valid, in_data, re,
    output in_ready, data_out, empty, full, num_in_fifo, pix_idx, frame_done, frame_cnt, err
  );

  modport master (
    output in_valid, in_data, re,
    input  in_ready, data_out, empty, full, num_in_fifo, pix_idx, frame_done, frame_cnt, err
  );
endinterface

// File: rtl/pixel_buffer_mux.sv
// Round-robin merge of NUM_CH pixel streams into one FWFT FIFO with hardware frame counting.
// Optional sticky protocol checker enabled by defining PIXEL_BUFFER_MUX_ERR_EN.
module pixel_buffer_mux #(
  parameter int NUM_CH       = 2,
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 64,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic               clk,
  input  logic               rst_b,
  pixel_buffer_mux_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int PIX_W = $clog2(FRAME_PIXELS);
  localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [RR_W-1:0]   r_rr_ptr;
  logic [RR_W-1:0]   w_grant;
  logic              w_grant_vld;
  logic [NUM_CH-1:0] w_in_ready;
  logic              w_wr;
  logic              w_rd;
  logic              w_last;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic [PIX_W-1:0]  r_pix_idx;
  logic [15:0]       r_frame_cnt;
  logic              r_frame_done;

  // Round-robin grant: scan downward so the channel closest to rr_ptr wins last.
  always_comb begin
    logic [RR_W-1:0] w_idx;
    w_grant     = r_rr_ptr;
    w_grant_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx       = RR_W'((int'(r_rr_ptr) + k) % NUM_CH);
      w_grant     = bus.in_valid[w_idx] ? w_idx : w_grant;
      w_grant_vld = w_grant_vld | bus.in_valid[w_idx];
    end
  end

  // Only the granted channel sees ready, and only while space is left.
  always_comb begin
    w_in_ready = '0;
    if (w_grant_vld && !r_full) begin
      w_in_ready[w_grant] = 1'b1;
    end else begin
      w_in_ready = '0;
    end
  end

  assign w_wr = w_grant_vld & ~r_full;
  assign w_rd = bus.re & ~r_empty;
  assign w_last = (r_pix_idx == PIX_W'(FRAME_PIXELS - 1));

  // Occupancy after this cycle's write/read pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr, w_rd})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.in_data[w_grant];
    end
  end

  // FIFO control and arbiter pointer.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rr_ptr <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == CNT_W'(0));
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_ptr <= (w_grant == RR_W'(NUM_CH - 1)) ? RR_W'(0) : w_grant + RR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // Frame position of the head pixel and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pix_idx    <= '0;
      r_frame_cnt  <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_rd & w_last;
      if (w_rd) begin
        if (w_last) begin
          r_pix_idx   <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_pix_idx   <= r_pix_idx + PIX_W'(1);
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.data_out    = r_mem[r_rd_ptr];
  assign bus.empty       = r_empty;
  assign bus.full        = r_full;
  assign bus.num_in_fifo = r_count;
  assign bus.pix_idx     = r_pix_idx;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_cnt   = r_frame_cnt;

`ifdef PIXEL_BUFFER_MUX_ERR_EN
  logic [NUM_CH-1:0]             r_pend_vld;
  logic [NUM_CH-1:0][DATA_W-1:0] r_pend_data;
  logic [NUM_CH-1:0]             w_viol;
  logic                          r_err;

  // A pending offer must stay asserted with unchanged data until accepted.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_viol
    assign w_viol[g] = r_pend_vld[g] &
                       (~bus.in_valid[g] | (bus.in_data[g] != r_pend_data[g]));
  end

  // Pending snapshot and sticky error flag.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_pend_vld  <= '0;
      r_pend_data <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pend_vld  <= bus.in_valid & ~w_in_ready;
      r_pend_data <= bus.in_data;
      r_err       <= r_err | (bus.re & r_empty) | (|w_viol);
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_buffer_mux.sv
// Directed bench for pixel_buffer_mux: 3 channels, 64-deep FIFO, 4-pixel frames.
module tb_pixel_buffer_mux;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 64;
  localparam int FRAME  = 4;

  logic clk;
  logic rst_b;
  int   errors = 0;
  int   checks = 0;
  int   seq [NUM_CH];
  int   writes;
  logic exp_err;

  pixel_buffer_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_PIXELS(FRAME)) bus ();

  pixel_buffer_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_PIXELS(FRAME)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(int ch, int s);
    return {ch[31:0], s[31:0]};
  endfunction

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load_data();
    for (int i = 0; i < NUM_CH; i++) bus.in_data[i] = mk(i, seq[i]);
  endtask

  // One clock: note handshakes before the edge, then present each accepted channel's next pixel.
  task automatic step();
    logic [NUM_CH-1:0] hs;
    hs = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hs[i]) begin
        seq[i]++;
        writes++;
      end
    end
    load_data();
  endtask

  task automatic do_reset();
    bus.in_valid = '0;
    bus.re       = 1'b0;
    rst_b        = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
    writes = 0;
    load_data();
  endtask

  initial begin
`ifdef PIXEL_BUFFER_MUX_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
    writes       = 0;
    bus.in_valid = '0;
    bus.re       = 1'b0;
    load_data();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_num", 64'(bus.num_in_fifo), 64'd0);
    check("rst_fdone", 64'(bus.frame_done), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_b = 1'b1;

    // Half fill from channel 0, then reset mid-operation.
    bus.in_valid = 3'b001;
    repeat (32) step();
    check("half_num", 64'(bus.num_in_fifo), 64'd32);
    bus.in_valid = '0;
    rst_b = 1'b0;
    #1;
    check("mid_rst_empty", 64'(bus.empty), 64'd1);
    check("mid_rst_num", 64'(bus.num_in_fifo), 64'd0);
    check("mid_rst_pix", 64'(bus.pix_idx), 64'd0);
    check("mid_rst_fcnt", 64'(bus.frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
    writes = 0;
    load_data();
    bus.in_valid = 3'b111;
    #1;
    check("post_rst_ready", 64'(bus.in_ready), 64'b001);

    // All channels valid, no reads: fills in order 0,1,2,...
    for (int n = 1; n <= DEPTH; n++) begin
      step();
      if (n == DEPTH - 1) begin
        check("fill63_full", 64'(bus.full), 64'd0);
        check("fill63_num", 64'(bus.num_in_fifo), 64'd63);
      end
    end
    check("fill_writes", 64'(writes), 64'd64);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_num", 64'(bus.num_in_fifo), 64'd64);
    check("full_ready", 64'(bus.in_ready), 64'd0);
    check("fill_head", bus.data_out, mk(0, 0));

    // Full with simultaneous read and channel-1 request: read only.
    bus.re       = 1'b1;
    bus.in_valid = 3'b010;
    #1;
    check("full_rw_ready", 64'(bus.in_ready), 64'd0);
    step();
    check("full_rw_num", 64'(bus.num_in_fifo), 64'd63);
    check("full_rw_full", 64'(bus.full), 64'd0);
    check("full_rw_head", bus.data_out, mk(1, 0));
    bus.re = 1'b0;
    #1;
    check("ch1_ready", 64'(bus.in_ready), 64'b010);
    step();
    check("ch1_num", 64'(bus.num_in_fifo), 64'd64);
    check("ch1_full", 64'(bus.full), 64'd1);

    // Drain everything and confirm the round-robin write order.
    bus.in_valid = '0;
    bus.re       = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < DEPTH - 1) check("drain", bus.data_out, mk((k + 1) % 3, (k + 1) / 3));
      else               check("drain_last", bus.data_out, mk(1, 21));
      step();
    end
    bus.re = 1'b0;
    check("drain_empty", 64'(bus.empty), 64'd1);
    check("drain_num", 64'(bus.num_in_fifo), 64'd0);
    check("drain_pix", 64'(bus.pix_idx), 64'd1);
    check("drain_fcnt", 64'(bus.frame_cnt), 64'd16);

    // Empty with simultaneous write and read: read ignored.
    do_reset();
    bus.in_valid = 3'b100;
    bus.re       = 1'b1;
    step();
    bus.in_valid = '0;
    bus.re       = 1'b0;
    check("empty_rw_empty", 64'(bus.empty), 64'd0);
    check("empty_rw_num", 64'(bus.num_in_fifo), 64'd1);
    check("empty_rw_data", bus.data_out, mk(2, 0));
    check("empty_rw_pix", 64'(bus.pix_idx), 64'd0);

    // Nine reads over 4-pixel frames.
    do_reset();
    bus.in_valid = 3'b001;
    repeat (9) step();
    bus.in_valid = '0;
    bus.re       = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      step();
      check("frame_done", 64'(bus.frame_done), (r == 4 || r == 8) ? 64'd1 : 64'd0);
    end
    bus.re = 1'b0;
    check("frame_cnt", 64'(bus.frame_cnt), 64'd2);
    check("frame_pix", 64'(bus.pix_idx), 64'd1);
    check("frame_empty", 64'(bus.empty), 64'd1);

    // Read strobe while empty.
    bus.re = 1'b1;
    step();
    bus.re = 1'b0;
    check("re_empty_err", 64'(bus.err), 64'(exp_err));
    check("re_empty_num", 64'(bus.num_in_fifo), 64'd0);
    check("re_empty_pix", 64'(bus.pix_idx), 64'd1);
    repeat (2) step();
    check("err_sticky", 64'(bus.err), 64'(exp_err));
    do_reset();
    check("err_cleared", 64'(bus.err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
